// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable. ADDI support via MC_MAIN_CTRL_ADDI_EN.
module mc_main_ctrl #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic [1:0] alu_op,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       pc_write,
   output logic       branch,
   output logic       ior_d,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t state_reg;
   state_t state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= state_t'(RESET_STATE);
      end else begin
         state_reg <= state_next;
      end
   end

   assign state = state_reg;

   always_comb begin
      state_next = FETCH;
      alu_op     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      ior_d      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;

      case (state_reg)
         FETCH: begin
            // PC+4 and IR load only commit in the cycle the fetch completes
            alu_src_b  = 2'b01;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            state_next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXEC;
               OP_BEQ:       state_next = BRANCH;
               OP_J:         state_next = JUMP;
`ifdef MC_MAIN_CTRL_ADDI_EN
               OP_ADDI:      state_next = ADDIEX;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            // IR holds until the next fetch, so opcode is still lw or sw here
            state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            ior_d      = 1'b1;
            state_next = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         MEMWR: begin
            ior_d      = 1'b1;
            mem_write  = 1'b1;
            state_next = mem_ready ? FETCH : MEMWR;
         end
         EXEC: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            branch     = 1'b1;
            state_next = FETCH;
         end
`ifdef MC_MAIN_CTRL_ADDI_EN
         ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = ADDIWB;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
`endif
         JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            state_next = FETCH;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed self-checking bench for mc_main_ctrl; ADDI expectations follow MC_MAIN_CTRL_ADDI_EN.
module tb_mc_main_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic [1:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic       pc_write;
   logic       branch;
   logic       ior_d;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       illegal_op;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   mc_main_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .pc_write(pc_write), .branch(branch), .ior_d(ior_d), .ir_write(ir_write),
      .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // advance one clock and settle 2 time units past the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b0; opcode = OP_RTYPE;
      #3;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (alu_src_b !== 2'b01) begin errors++; $display("FAIL reset_alu_src_b: got %b expected 01", alu_src_b); end
      checks++; if ({ir_write, pc_write, mem_write, reg_write, branch} !== 5'b0) begin errors++;
         $display("FAIL reset_we: got %b expected 00000", {ir_write, pc_write, mem_write, reg_write, branch}); end
      tick();
      rst_n = 1'b1;
      opcode = OP_LW; mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      checks++; if (state !== 4'd3) begin errors++; $display("FAIL reset_reach_memrd: got %0d expected 3", state); end
      tick();
      checks++; if (state !== 4'd3) begin errors++; $display("FAIL reset_memrd_stall: got %0d expected 3", state); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", state); end
      checks++; if (alu_src_b !== 2'b01) begin errors++; $display("FAIL async_reset_alu_src_b: got %b expected 01", alu_src_b); end
      checks++; if ({ir_write, pc_write, mem_write, reg_write, ior_d} !== 5'b0) begin errors++;
         $display("FAIL async_reset_we: got %b expected 00000", {ir_write, pc_write, mem_write, reg_write, ior_d}); end
      #1 rst_n = 1'b1;
      tick();
      checks++; if (state !== 4'd0 || ir_write !== 1'b0) begin errors++;
         $display("FAIL reset_fetch_wait: got state=%0d ir_write=%b expected state=0 ir_write=0", state, ir_write); end
      $display("reset: async reset from MEMRD done");
   endtask

   task automatic test_lw();
      opcode = OP_LW; mem_ready = 1'b1;
      #1;
      checks++; if (state !== 4'd0 || alu_op !== 2'b00 || ir_write !== 1'b1 || pc_write !== 1'b1 || reg_write !== 1'b0) begin errors++;
         $display("FAIL lw_s0: got state=%0d alu_op=%b ir_write=%b pc_write=%b reg_write=%b expected 0 00 1 1 0",
                  state, alu_op, ir_write, pc_write, reg_write); end
      tick();
      checks++; if (state !== 4'd1 || alu_op !== 2'b00 || alu_src_b !== 2'b11 || reg_write !== 1'b0) begin errors++;
         $display("FAIL lw_s1: got state=%0d alu_op=%b alu_src_b=%b reg_write=%b expected 1 00 11 0", state, alu_op, alu_src_b, reg_write); end
      tick();
      checks++; if (state !== 4'd2 || alu_op !== 2'b00 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin errors++;
         $display("FAIL lw_s2: got state=%0d alu_op=%b alu_src_a=%b alu_src_b=%b expected 2 00 1 10", state, alu_op, alu_src_a, alu_src_b); end
      tick();
      checks++; if (state !== 4'd3 || ior_d !== 1'b1 || reg_write !== 1'b0 || mem_to_reg !== 1'b0) begin errors++;
         $display("FAIL lw_s3: got state=%0d ior_d=%b reg_write=%b mem_to_reg=%b expected 3 1 0 0", state, ior_d, reg_write, mem_to_reg); end
      tick();
      checks++; if (state !== 4'd4 || reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin errors++;
         $display("FAIL lw_s4: got state=%0d reg_write=%b mem_to_reg=%b reg_dst=%b expected 4 1 1 0", state, reg_write, mem_to_reg, reg_dst); end
      tick();
      checks++; if (state !== 4'd0 || reg_write !== 1'b0 || mem_to_reg !== 1'b0) begin errors++;
         $display("FAIL lw_end: got state=%0d reg_write=%b mem_to_reg=%b expected 0 0 0", state, reg_write, mem_to_reg); end
      $display("lw: sequence 0,1,2,3,4,0 done");
   endtask

   task automatic test_rtype();
      opcode = OP_RTYPE; mem_ready = 1'b1;
      tick();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL rtype_s1: got %0d expected 1", state); end
      tick();
      checks++; if (state !== 4'd6 || alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin errors++;
         $display("FAIL rtype_s6: got state=%0d alu_op=%b alu_src_a=%b alu_src_b=%b expected 6 10 1 00", state, alu_op, alu_src_a, alu_src_b); end
      tick();
      checks++; if (state !== 4'd7 || reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin errors++;
         $display("FAIL rtype_s7: got state=%0d reg_dst=%b reg_write=%b mem_to_reg=%b expected 7 1 1 0", state, reg_dst, reg_write, mem_to_reg); end
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL rtype_end: got %0d expected 0", state); end
      $display("rtype: sequence 0,1,6,7,0 done");
   endtask

   task automatic test_branch_jump();
      opcode = OP_BEQ; mem_ready = 1'b1;
      tick();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL beq_s1: got %0d expected 1", state); end
      tick();
      checks++; if (state !== 4'd8 || alu_op !== 2'b01 || branch !== 1'b1 || pc_src !== 2'b01 || pc_write !== 1'b0) begin errors++;
         $display("FAIL beq_s8: got state=%0d alu_op=%b branch=%b pc_src=%b pc_write=%b expected 8 01 1 01 0",
                  state, alu_op, branch, pc_src, pc_write); end
      tick();
      checks++; if (state !== 4'd0 || branch !== 1'b0) begin errors++; $display("FAIL beq_end: got state=%0d branch=%b expected 0 0", state, branch); end
      $display("beq: sequence 0,1,8,0 done");
      opcode = OP_J;
      tick();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL j_s1: got %0d expected 1", state); end
      tick();
      checks++; if (state !== 4'd11 || pc_write !== 1'b1 || pc_src !== 2'b10 || branch !== 1'b0) begin errors++;
         $display("FAIL j_s11: got state=%0d pc_write=%b pc_src=%b branch=%b expected 11 1 10 0", state, pc_write, pc_src, branch); end
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL j_end: got %0d expected 0", state); end
      $display("j: sequence 0,1,11,0 done");
   endtask

   task automatic test_mem_wait();
      opcode = OP_SW; mem_ready = 1'b1;
      tick();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL sw_s1: got %0d expected 1", state); end
      mem_ready = 1'b0;
      tick();
      checks++; if (state !== 4'd2) begin errors++; $display("FAIL sw_s2_ignores_ready: got %0d expected 2", state); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (state !== 4'd5 || mem_write !== 1'b1 || ior_d !== 1'b1) begin errors++;
            $display("FAIL sw_hold%0d: got state=%0d mem_write=%b ior_d=%b expected 5 1 1", i, state, mem_write, ior_d); end
      end
      mem_ready = 1'b1;
      tick();
      checks++; if (state !== 4'd0 || mem_write !== 1'b0) begin errors++; $display("FAIL sw_end: got state=%0d mem_write=%b expected 0 0", state, mem_write); end
      $display("sw: MEMWR held 4 cycles done");
      mem_ready = 1'b0; opcode = OP_RTYPE;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin errors++;
            $display("FAIL fetch_wait%0d: got state=%0d ir_write=%b pc_write=%b expected 0 0 0", i, state, ir_write, pc_write); end
         if (i < 2) tick();
      end
      mem_ready = 1'b1;
      #1;
      checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin errors++;
         $display("FAIL fetch_ready: got ir_write=%b pc_write=%b expected 1 1", ir_write, pc_write); end
      tick();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL fetch_done: got %0d expected 1", state); end
      tick(); tick(); tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL fetch_rtype_end: got %0d expected 0", state); end
      $display("fetch: wait states done");
   endtask

   task automatic test_illegal();
      opcode = OP_BAD; mem_ready = 1'b1;
      #1;
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_fetch: got %b expected 0", illegal_op); end
      tick();
      checks++; if (state !== 4'd1 || illegal_op !== 1'b1) begin errors++;
         $display("FAIL illegal_s1: got state=%0d illegal_op=%b expected 1 1", state, illegal_op); end
      tick();
      checks++; if (state !== 4'd0 || illegal_op !== 1'b0) begin errors++;
         $display("FAIL illegal_end: got state=%0d illegal_op=%b expected 0 0", state, illegal_op); end
      $display("illegal: opcode 111111 done");
   endtask

   task automatic test_addi();
      opcode = OP_ADDI; mem_ready = 1'b1;
      tick();
`ifdef MC_MAIN_CTRL_ADDI_EN
      checks++; if (state !== 4'd1 || illegal_op !== 1'b0) begin errors++;
         $display("FAIL addi_s1: got state=%0d illegal_op=%b expected 1 0", state, illegal_op); end
      tick();
      checks++; if (state !== 4'd9 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b00) begin errors++;
         $display("FAIL addi_s9: got state=%0d alu_src_a=%b alu_src_b=%b alu_op=%b expected 9 1 10 00", state, alu_src_a, alu_src_b, alu_op); end
      tick();
      checks++; if (state !== 4'd10 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin errors++;
         $display("FAIL addi_s10: got state=%0d reg_write=%b reg_dst=%b mem_to_reg=%b expected 10 1 0 0", state, reg_write, reg_dst, mem_to_reg); end
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL addi_end: got %0d expected 0", state); end
      $display("addi: enabled sequence 0,1,9,10,0 done");
`else
      checks++; if (state !== 4'd1 || illegal_op !== 1'b1) begin errors++;
         $display("FAIL addi_illegal: got state=%0d illegal_op=%b expected 1 1", state, illegal_op); end
      tick();
      checks++; if (state !== 4'd0 || illegal_op !== 1'b0) begin errors++;
         $display("FAIL addi_end: got state=%0d illegal_op=%b expected 0 0", state, illegal_op); end
      $display("addi: disabled, treated as illegal done");
`endif
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype();
      test_branch_jump();
      test_mem_wait();
      test_illegal();
      test_addi();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
